// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one of N requesters at a time using a rotating
// priority pointer. A grant is held while its request stays high, up to
// MAX_HOLD cycles, after which it is preempted. Every grant is followed by at
// least one idle cycle.
module rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned ID_W     = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid,
    output logic            preempt
);

    typedef enum logic {StIdle, StBusy} state_e;

    // Hold count at which the grant is removed; unused when MAX_HOLD is 0.
    localparam logic [CNT_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]  LastId   = ID_W'(N - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              preempt_q, preempt_d;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    int unsigned       scan_idx;
    logic [ID_W-1:0]   next_ptr;

    // Rotating-priority search: first set request at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = (32'(ptr_q) + k) % N;
            if (!win_found && req[ID_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(scan_idx);
            end
        end
    end

    // Pointer moves just past the requester whose grant is ending.
    always_comb begin
        next_ptr = (grant_id_q == LastId) ? '0 : grant_id_q + 1'b1;
    end

    // Next-state logic: arbitrate in idle; release, preempt or hold in busy.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        preempt_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    grant_id_d       = win_idx;
                    hold_cnt_d       = '0;
                    state_d          = StBusy;
                end
            end
            StBusy: begin
                // Release is checked first so a simultaneous timeout is not flagged.
                if (!req[grant_id_q]) begin
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    state_d = StIdle;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HoldLast)) begin
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    state_d   = StIdle;
                    preempt_d = 1'b1;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = |grant_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: one instance with MAX_HOLD=4 and one with
// preemption disabled, sharing clock, reset and request stimulus.
module tb_rr_arbiter;

    localparam int unsigned N     = 8;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    grant4, grant0;
    logic [ID_W-1:0] id4, id0;
    logic            valid4, valid0, pre4, pre0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.N(N), .ID_W(ID_W), .CNT_W(CNT_W), .MAX_HOLD(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant4),
        .grant_id    (id4),
        .grant_valid (valid4),
        .preempt     (pre4)
    );

    rr_arbiter #(.N(N), .ID_W(ID_W), .CNT_W(CNT_W), .MAX_HOLD(0)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant0),
        .grant_id    (id0),
        .grant_valid (valid0),
        .preempt     (pre0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Outputs change on posedge; sample and drive on negedge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk4(input string tag, input logic [7:0] g, input int id, input logic p);
        check_eq({tag, ".grant"}, 32'(grant4), 32'(g));
        check_eq({tag, ".valid"}, 32'(valid4), 32'(g != 8'h00));
        check_eq({tag, ".preempt"}, 32'(pre4), 32'(p));
        if (g != 8'h00) check_eq({tag, ".id"}, 32'(id4), 32'(id));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_g;

        // Reset state
        do_reset();
        chk4("reset", 8'h00, 0, 1'b0);
        check_eq("reset.id", 32'(id4), 32'd0);

        // Asynchronous reset mid-grant
        req = 8'h04;
        tick();
        chk4("busy_pre_rst", 8'h04, 2, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk4("async_rst", 8'h00, 0, 1'b0);
        check_eq("async_rst.id", 32'(id4), 32'd0);
        tick();
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk4("idle_no_req", 8'h00, 0, 1'b0);
        end

        // Single requester: three sampled cycles of req, release on the fourth edge
        req = 8'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("single", 8'h10, 4, 1'b0);
            check_eq("single.dut0_grant", 32'(grant0), 32'h10);
            if (i == 2) req = 8'h00;
        end
        tick();
        chk4("single_release", 8'h00, 0, 1'b0);
        tick();
        chk4("single_idle", 8'h00, 0, 1'b0);

        // Rotation with all requesting, MAX_HOLD=4
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            for (int c = 0; c < 4; c++) begin
                tick();
                chk4("rot_hold", exp_g, k % 8, 1'b0);
            end
            tick();
            chk4("rot_preempt", 8'h00, 0, 1'b1);
        end

        // Pointer wrap: after 7 releases, ptr=0 so requester 0 beats 7
        do_reset();
        req = 8'h80;
        tick();
        chk4("wrap_g7", 8'h80, 7, 1'b0);
        req = 8'h00;
        tick();
        chk4("wrap_rel7", 8'h00, 0, 1'b0);
        req = 8'h81;
        tick();
        chk4("wrap_g0", 8'h01, 0, 1'b0);
        req = 8'h80;
        tick();
        chk4("wrap_rel0", 8'h00, 0, 1'b0);
        req = 8'h81;
        tick();
        chk4("wrap_g7b", 8'h80, 7, 1'b0);

        // Release coinciding with timeout: release wins, ptr moves to 3
        do_reset();
        req = 8'h04;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk4("rbt_hold", 8'h04, 2, 1'b0);
        end
        req = 8'h00;
        tick();
        chk4("rbt_release", 8'h00, 0, 1'b0);
        // With ptr=3, bits 0 and 2 pending: scan 3..7 then 0 -> requester 0
        req = 8'h05;
        tick();
        chk4("rbt_ptr3", 8'h01, 0, 1'b0);
        req = 8'h00;
        tick();

        // Preemption disabled: grant held, counter saturates
        do_reset();
        req = 8'h03;
        for (int c = 0; c < 300; c++) begin
            tick();
            check_eq("nopre.grant", 32'(grant0), 32'h01);
            check_eq("nopre.preempt", 32'(pre0), 32'd0);
        end
        check_eq("nopre.hold_sat", 32'(u_dut0.hold_cnt_q), 32'd255);
        check_eq("nopre.id", 32'(id0), 32'd0);
        check_eq("nopre.valid", 32'(valid0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
